// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder that reuses one SLICE-bit carry-lookahead slice,
// LSB slice first, with the inter-slice carry held in a register.
module cla_seq_adder #(
  parameter int WIDTH = 48,
  parameter int SLICE = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_opA;
  logic [SLICE-1:0] w_opB;
  logic [SLICE-1:0] w_gen;
  logic [SLICE-1:0] w_prop;
  logic [SLICE:0]   w_carry;
  logic [SLICE-1:0] w_sliceSum;
  logic             w_lastSlice;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign w_lastSlice = (r_idx == IW'(NSLICE - 1));

  always_comb begin
    w_opA = '0;
    w_opB = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IW'(k)) begin
        w_opA = r_a[k*SLICE +: SLICE];
        w_opB = r_b[k*SLICE +: SLICE];
      end
    end
  end

  assign w_gen  = w_opA & w_opB;
  assign w_prop = w_opA ^ w_opB;

  // Each carry is a flat sum-of-products over generate/propagate terms, so no
  // carry depends on the previous carry bit.
  always_comb begin
    logic vAcc;
    logic vProd;
    vAcc       = 1'b0;
    vProd      = 1'b1;
    w_carry    = '0;
    w_carry[0] = r_carry;
    for (int i = 0; i < SLICE; i++) begin
      vAcc  = 1'b0;
      vProd = 1'b1;
      for (int j = i; j >= 0; j--) begin
        vAcc  = vAcc | (vProd & w_gen[j]);
        vProd = vProd & w_prop[j];
      end
      w_carry[i+1] = vAcc | (vProd & r_carry);
    end
  end

  assign w_sliceSum = w_prop ^ w_carry[SLICE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[k*SLICE +: SLICE] <= w_sliceSum;
            end
          end
          r_carry <= w_carry[SLICE];
          r_idx   <= r_idx + IW'(1);
          if (w_lastSlice) begin
            r_cout  <= w_carry[SLICE];
            r_ovf   <= w_carry[SLICE-1] ^ w_carry[SLICE];
            r_idx   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed and random operations checked
// against a reference add model through an expected-result queue.
module tb_cla_seq_adder;

  localparam int WIDTH  = 48;
  localparam int SLICE  = 12;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  result_t expQ[$];
  int nChecks = 0;
  int nFail   = 0;

  cla_seq_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  function automatic result_t refModel(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                       input logic icin);
    result_t r;
    logic [WIDTH:0] t;
    t = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, icin};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (ia[WIDTH-1] == ib[WIDTH-1]) && (t[WIDTH-1] != ia[WIDTH-1]);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] randWord();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[WIDTH-1:0];
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("rst_in_ready", in_ready, 1);
    checkValue("rst_out_valid", out_valid, 0);
    checkValue("rst_busy", busy, 0);
    checkValue("rst_sum", sum, 0);
    checkValue("rst_cout", cout, 0);
    checkValue("rst_ovf", ovf, 0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one operation, records its expected result on the accept edge, then
  // scrambles the operand bus to show it is no longer sampled.
  task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                               input logic icin);
    @(negedge clk);
    checkValue("in_ready_idle", in_ready, 1);
    a        = ia;
    b        = ib;
    cin      = icin;
    in_valid = 1'b1;
    @(posedge clk);
    expQ.push_back(refModel(ia, ib, icin));
    #1;
    in_valid = 1'b0;
    a        = randWord();
    b        = randWord();
    cin      = 1'($urandom_range(0, 1));
  endtask

  // Waits for the result, checks latency and value, optionally holds the result
  // with back-pressure while offering new operands, then optionally releases it.
  task automatic checkOutput(input string tag, input int holdCycles, input bit doRelease);
    int n;
    result_t e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkValue({tag, "_latency"}, n, NSLICE);
    if (!out_valid) return;
    if (expQ.size() == 0) begin
      checkValue({tag, "_queue"}, 0, 1);
      return;
    end
    e = expQ.pop_front();
    checkValue({tag, "_sum"}, sum, e.sum);
    checkValue({tag, "_cout"}, cout, e.cout);
    checkValue({tag, "_ovf"}, ovf, e.ovf);
    checkValue({tag, "_busy"}, busy, 1);
    checkValue({tag, "_in_ready"}, in_ready, 0);
    out_ready = 1'b0;
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = randWord();
      b        = randWord();
      @(posedge clk);
      #1;
      checkValue({tag, "_hold_valid"}, out_valid, 1);
      checkValue({tag, "_hold_sum"}, sum, e.sum);
      checkValue({tag, "_hold_flags"}, {cout, ovf}, {e.cout, e.ovf});
      checkValue({tag, "_hold_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (doRelease) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkValue({tag, "_rel_valid"}, out_valid, 0);
      checkValue({tag, "_rel_in_ready"}, in_ready, 1);
      checkValue({tag, "_rel_busy"}, busy, 0);
    end
  endtask

  initial begin
    bit sawValid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    checkValue("init_in_ready", in_ready, 1);
    checkValue("init_out_valid", out_valid, 0);
    checkValue("init_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] carry across slice 0->1");
    applyStimulus(48'h000000000FFF, 48'h000000000001, 1'b0);
    checkOutput("t2", 0, 1'b1);

    $display("[TB] reset while holding a result");
    applyStimulus(48'h0000ABCDEF01, 48'h000012345678, 1'b1);
    checkOutput("t1", 0, 1'b0);
    applyReset();

    $display("[TB] carry through every slice");
    applyStimulus(48'hFFFFFFFFFFFF, 48'h000000000000, 1'b1);
    checkOutput("t3", 0, 1'b1);

    $display("[TB] signed overflow cases");
    applyStimulus(48'h7FFFFFFFFFFF, 48'h000000000001, 1'b0);
    checkOutput("t4a", 0, 1'b1);
    applyStimulus(48'h800000000000, 48'h800000000000, 1'b0);
    checkOutput("t4b", 0, 1'b1);

    $display("[TB] back-pressure in DONE");
    applyStimulus(48'h00FF00FF00FF, 48'h0F0F0F0F0F0F, 1'b0);
    checkOutput("t5", 5, 1'b1);
    applyStimulus(48'h111111111111, 48'h222222222222, 1'b1);
    checkOutput("t5_next", 0, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(48'hDEADBEEFCAFE, 48'h0123456789AB, 1'b0);
    @(posedge clk);
    @(posedge clk);
    applyReset();
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkValue("t6_no_valid", sawValid, 0);
    applyStimulus(48'h123456789ABC, 48'h0FEDCBA98765, 1'b1);
    checkOutput("t6", 0, 1'b1);

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randWord(), randWord(), 1'($urandom_range(0, 1)));
      checkOutput("rnd", i % 3, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
